// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and glitch-filters A/B, tracks
// phase, and produces step/dir pulses, a modular position and a sticky error.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   a, b          - raw quadrature channels (asynchronous)
//   en            - count enable (phase tracking continues when low)
//   clr_err       - synchronous clear of err
//   step          - one-cycle pulse per valid transition
//   dir           - direction of last valid transition (1=up)
//   pos           - CNT_W-bit modular position
//   err           - sticky illegal-transition flag
module quad_decoder #(
    parameter int CNT_W = 8,
    parameter int FILT  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             en,
    input  logic             clr_err,
    output logic             step,
    output logic             dir,
    output logic [CNT_W-1:0] pos,
    output logic             err
);

    localparam logic [3:0] FILT_M1 = 4'(FILT - 1);
    localparam logic [4:0] INIT_N  = 5'(FILT + 2);

    logic             a_m_q, a_s_q, b_m_q, b_s_q;
    logic [3:0]       a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic             a_f_q, a_f_d, b_f_q, b_f_d;
    logic [1:0]       ph_q, ph_d;
    logic [4:0]       init_q, init_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             err_q, err_d;

    logic [1:0]       cur;
    logic [1:0]       diff;
    logic             up;

    function automatic logic [1:0] nxt_up(input logic [1:0] p);
        case (p)
            2'b00:   nxt_up = 2'b01;
            2'b01:   nxt_up = 2'b11;
            2'b11:   nxt_up = 2'b10;
            default: nxt_up = 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            a_m_q   <= 1'b0;
            a_s_q   <= 1'b0;
            b_m_q   <= 1'b0;
            b_s_q   <= 1'b0;
            a_cnt_q <= '0;
            b_cnt_q <= '0;
            a_f_q   <= 1'b0;
            b_f_q   <= 1'b0;
            ph_q    <= 2'b00;
            init_q  <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            a_m_q   <= a;
            a_s_q   <= a_m_q;
            b_m_q   <= b;
            b_s_q   <= b_m_q;
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
            a_f_q   <= a_f_d;
            b_f_q   <= b_f_d;
            ph_q    <= ph_d;
            init_q  <= init_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        a_f_d   = a_f_q;
        b_f_d   = b_f_q;
        ph_d    = ph_q;
        init_d  = init_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        pos_d   = pos_q;
        err_d   = clr_err ? 1'b0 : err_q;
        cur     = {a_f_q, b_f_q};
        diff    = cur ^ ph_q;
        up      = 1'b0;

        if (init_q != INIT_N) begin
            // Init: adopt the idle input level as the reference phase
            // so a non-00 resting position does not look like a move.
            init_d  = init_q + 5'd1;
            a_f_d   = a_s_q;
            b_f_d   = b_s_q;
            a_cnt_d = '0;
            b_cnt_d = '0;
            ph_d    = {a_s_q, b_s_q};
        end else begin
            if (a_s_q != a_f_q) begin
                if (a_cnt_q == FILT_M1) begin
                    a_f_d   = a_s_q;
                    a_cnt_d = '0;
                end else begin
                    a_cnt_d = a_cnt_q + 4'd1;
                end
            end else begin
                a_cnt_d = '0;
            end

            if (b_s_q != b_f_q) begin
                if (b_cnt_q == FILT_M1) begin
                    b_f_d   = b_s_q;
                    b_cnt_d = '0;
                end else begin
                    b_cnt_d = b_cnt_q + 4'd1;
                end
            end else begin
                b_cnt_d = '0;
            end

            ph_d = cur;
            up   = (cur == nxt_up(ph_q));
            case (diff)
                2'b11: err_d = 1'b1;
                2'b01, 2'b10: begin
                    if (en) begin
                        step_d = 1'b1;
                        dir_d  = up;
                        pos_d  = up ? pos_q + CNT_W'(1)
                                    : pos_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign step = step_q;
    assign dir  = dir_q;
    assign pos  = pos_q;
    assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed quadrature vectors, step pulses
// checked by a scoreboard monitor, state checked at fixed points.
module tb_quad_decoder;

    localparam int FILT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       a, b, en, clr_err;
    logic       step, dir, err;
    logic [7:0] pos;

    typedef struct {
        logic       d;
        logic [7:0] p;
        int         c;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ncmp = 0;
    int   nbad = 0;

    quad_decoder #(.CNT_W(8), .FILT(FILT)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
        .clr_err(clr_err), .step(step), .dir(dir),
        .pos(pos), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every step pulse must match the oldest expected move.
    always @(negedge clk) begin
        if (!rst && step) begin
            if (q.size() == 0) begin
                ncmp++;
                nbad++;
                $display("FAIL unexpected_step: got step at cyc %0d expected none",
                         cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("step_dir", int'(dir), int'(e.d));
                chk("step_pos", int'(pos), int'(e.p));
                chk("step_cyc", cyc, e.c);
            end
        end
    end

    // Drive a phase at a negedge; optionally expect one step.
    task automatic drv(input logic [1:0] ab, input bit ex,
                       input logic d, input logic [7:0] p,
                       input int hold);
        exp_t e;
        {a, b} = ab;
        if (ex) begin
            e.d = d;
            e.p = p;
            e.c = cyc + FILT + 3;
            q.push_back(e);
        end
        repeat (hold) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; a = 1'b0; b = 1'b0; en = 1'b1; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pos", int'(pos), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Four up steps
        drv(2'b01, 1, 1'b1, 8'd1, 10);
        drv(2'b11, 1, 1'b1, 8'd2, 10);
        drv(2'b10, 1, 1'b1, 8'd3, 10);
        drv(2'b00, 1, 1'b1, 8'd4, 10);
        chk("up4_pos", int'(pos), 4);
        chk("up4_dir", int'(dir), 1);
        chk("up4_err", int'(err), 0);

        // Reset to pos=0, then one down step wraps to 255
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst2_pos", int'(pos), 0);
        drv(2'b10, 1, 1'b0, 8'd255, 10);
        chk("down_pos", int'(pos), 255);
        chk("down_dir", int'(dir), 0);

        // 2-cycle glitch on a is filtered out
        drv(2'b00, 0, 1'b0, 8'd0, 2);
        drv(2'b10, 0, 1'b0, 8'd0, 10);
        chk("glitch_pos", int'(pos), 255);
        // Stable change: up step wraps 255 -> 0
        drv(2'b00, 1, 1'b1, 8'd0, 10);
        chk("wrap_pos", int'(pos), 0);

        // Illegal 00 -> 11
        drv(2'b11, 0, 1'b0, 8'd0, 10);
        chk("ill_err", int'(err), 1);
        chk("ill_pos", int'(pos), 0);
        chk("ill_dir", int'(dir), 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_err", int'(err), 0);

        // clr_err coincident with new illegal 11 -> 00: err stays set
        drv(2'b00, 0, 1'b0, 8'd0, FILT + 2);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("coinc_err", int'(err), 1);
        repeat (3) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr2_err", int'(err), 0);

        // en=0 for three up steps, then one counted step
        en = 1'b0;
        drv(2'b01, 0, 1'b0, 8'd0, 10);
        drv(2'b11, 0, 1'b0, 8'd0, 10);
        drv(2'b10, 0, 1'b0, 8'd0, 10);
        chk("en0_pos", int'(pos), 0);
        en = 1'b1;
        drv(2'b00, 1, 1'b1, 8'd1, 10);
        chk("en1_pos", int'(pos), 1);
        chk("en1_err", int'(err), 0);

        // Reset with a=b=1 held: no false error or step
        rst = 1'b1;
        a = 1'b1;
        b = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("idle11_err", int'(err), 0);
        chk("idle11_pos", int'(pos), 0);
        drv(2'b10, 1, 1'b1, 8'd1, 10);
        chk("idle11_up_pos", int'(pos), 1);
        chk("idle11_up_err", int'(err), 0);

        chk("sb_left", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter CNT_W, default 8, width of position counter.
REQ-002 Parameter FILT, default 3, glitch-filter length in clk cycles (legal 1..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a  input  1  quadrature channel A, asynchronous to clk.
REQ-006 b  input  1  quadrature channel B, asynchronous to clk.
REQ-007 en  input  1  count enable; 0 freezes pos, step, dir but phase tracking continues.
REQ-008 clr_err  input  1  synchronous clear of err.
REQ-009 step  output  1  one-cycle pulse per valid quadrature transition.
REQ-010 dir  output  1  direction of last valid transition; 1=up, 0=down.
REQ-011 pos  output  CNT_W  position count, modular.
REQ-012 err  output  1  sticky illegal-transition flag.

Function
REQ-013 a and b SHALL each pass a 2-flop synchronizer (a_s, b_s).
REQ-014 Each channel SHALL have an independent filter: a counter increments while the synchronized value differs from the filtered value and clears when they match.
REQ-015 The filtered value SHALL take the synchronized value on the edge where the counter reaches FILT; the counter then clears.
REQ-016 A pulse shorter than FILT cycles at the synchronizer output SHALL NOT change the filtered value.
REQ-017 Phase SHALL be {A_f,B_f}; up sequence 00->01->11->10->00, down is the reverse.
REQ-018 A one-bit phase change in up order SHALL, when en=1, assert step for one cycle, set dir=1, and increment pos.
REQ-019 A one-bit phase change in down order SHALL, when en=1, assert step for one cycle, set dir=0, and decrement pos.
REQ-020 pos SHALL wrap modulo 2^CNT_W: max+1 gives 0; 0-1 gives all-ones.
REQ-021 Both filtered bits changing on the same edge SHALL set err=1, leave pos and dir unchanged, keep step=0, and adopt the new phase as reference.
REQ-022 err SHALL clear only on clr_err=1 or rst; if clr_err and a new illegal transition coincide, err SHALL stay 1.
REQ-023 With en=0, phase changes SHALL still update the reference phase and err detection, but step stays 0 and pos and dir hold.
REQ-024 step, dir, pos and err SHALL be registered, updating on the edge after the filtered-phase change.
REQ-025 Total latency SHALL be FILT+3 edges: a clean input change before edge k gives step high in the cycle after edge k+FILT+2 (k+5 for FILT=3).
REQ-026 No pos change or step SHALL occur without a filtered-phase change.

Reset
REQ-027 rst=1 SHALL clear the synchronizers, filter counters, filtered values, step, dir, pos and err to 0.
REQ-028 After rst deasserts, an init phase of FILT+2 cycles SHALL load the filtered values directly from the synchronized values, with no step, err or pos change.
REQ-029 Decoding SHALL start on the first edge after the init phase, using the loaded phase as reference, so a non-00 idle input gives no false error.
REQ-030 rst asserted mid-operation SHALL abort any pending filter count and re-run REQ-027 to REQ-029.

Verification
REQ-031 Post-reset a=b=0, en=1; drive 4 up steps (01,11,10,00), each held 10 cycles -> 4 step pulses, pos=4, dir=1, err=0.
REQ-032 pos=0; one down step (00->10) -> pos=255 (CNT_W=8), dir=0; step pulse appears FILT+3 edges after the input change.
REQ-033 FILT=3; 2-cycle glitch on a -> no step, pos unchanged; a 3-cycle-stable change -> exactly one step.
REQ-034 Phase 00, drive a=b=1 on the same cycle -> err=1, pos and dir unchanged, step=0; clr_err pulse -> err=0 next cycle.
REQ-035 en=0 during 3 up steps, then en=1 with one more up step -> pos increments by 1 only, err=0.
REQ-036 Hold a=b=1 through rst, release rst -> no err or step during or after init; next valid up step (11->10) increments pos.
